// File: rtl/uart_transmitter_if.sv
// Byte-in / serial-out bundle for uart_transmitter. The master side drives the
// byte strobe, and the slave (the transmitter) drives the line and the status flags.
interface uart_transmitter_if;
  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;
  logic       o_TX_Serial;
  logic       o_TX_Active;
  logic       o_TX_Done;
  logic       o_TX_Ready;

  modport master (
    output i_TX_DV, i_TX_Byte,
    input  o_TX_Serial, o_TX_Active, o_TX_Done, o_TX_Ready
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte,
    output o_TX_Serial, o_TX_Active, o_TX_Done, o_TX_Ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register, so that back-to-back
// frames go out with no idle gap. All outputs come straight from flops.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  uart_transmitter_if.slave bus
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] clkCnt, clkCntNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       shiftReg, shiftNext;
  logic [7:0]       holdReg, holdNext;
  logic             holdEmpty, holdEmptyNext;
  logic             serial, serialNext;
  logic             active, activeNext;
  logic             done, doneNext;
  logic             bitEnd;

  assign bitEnd = (clkCnt == CNT_LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= IDLE;
      clkCnt    <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      holdReg   <= '0;
      holdEmpty <= 1'b1;
      serial    <= 1'b1;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      clkCnt    <= clkCntNext;
      bitIdx    <= bitIdxNext;
      shiftReg  <= shiftNext;
      holdReg   <= holdNext;
      holdEmpty <= holdEmptyNext;
      serial    <= serialNext;
      active    <= activeNext;
      done      <= doneNext;
    end
  end

  always_comb begin
    stateNext     = state;
    clkCntNext    = bitEnd ? '0 : clkCnt + 1'b1;
    bitIdxNext    = bitIdx;
    shiftNext     = shiftReg;
    holdNext      = holdReg;
    holdEmptyNext = holdEmpty;
    serialNext    = serial;
    activeNext    = active;
    doneNext      = 1'b0;

    // Mid-frame strobes go to holding, except on the last stop cycle, where
    // the STOP branch decides where the byte lands.
    if (state != IDLE && bus.i_TX_DV && holdEmpty && !(state == STOP && bitEnd)) begin
      holdNext      = bus.i_TX_Byte;
      holdEmptyNext = 1'b0;
    end

    unique case (state)
      IDLE: begin
        clkCntNext = '0;
        serialNext = 1'b1;
        activeNext = 1'b0;
        if (bus.i_TX_DV) begin
          shiftNext  = bus.i_TX_Byte;
          stateNext  = START;
          serialNext = 1'b0;
          activeNext = 1'b1;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext  = DATA;
          bitIdxNext = '0;
          serialNext = shiftReg[0];
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitIdx == 3'd7) begin
            stateNext  = STOP;
            bitIdxNext = '0;
            serialNext = 1'b1;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
            shiftNext  = shiftReg >> 1;
            serialNext = shiftReg[1];
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          doneNext = 1'b1;
          if (!holdEmpty) begin
            shiftNext  = holdReg;
            stateNext  = START;
            serialNext = 1'b0;
            // A strobe on this cycle refills holding as it empties.
            if (bus.i_TX_DV) holdNext = bus.i_TX_Byte;
            else             holdEmptyNext = 1'b1;
          end else if (bus.i_TX_DV) begin
            shiftNext  = bus.i_TX_Byte;
            stateNext  = START;
            serialNext = 1'b0;
          end else begin
            stateNext  = IDLE;
            serialNext = 1'b1;
            activeNext = 1'b0;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.o_TX_Serial = serial;
  assign bus.o_TX_Active = active;
  assign bus.o_TX_Done   = done;
  assign bus.o_TX_Ready  = holdEmpty;
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a queue-based line model compared
// every cycle, plus hand-computed waveform and timing expectations.
module tb_uart_transmitter;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  uart_transmitter_if bus();

  uart_transmitter #(.CLKS_PER_BIT(C)) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the line is a queue of per-cycle bit values; a frame is its 10*C
  // cycles appended at the edge that starts it.
  bit       mWave[$];
  bit       mHeld = 0;
  bit [7:0] mHoldByte = '0;
  bit       mDone = 0;
  bit       mValid = 0;
  bit [7:0] mLog[$];

  task automatic startFrame(input bit [7:0] b);
    for (int unsigned i = 0; i < C; i++) mWave.push_back(1'b0);
    for (int unsigned n = 0; n < 8; n++)
      for (int unsigned i = 0; i < C; i++) mWave.push_back(b[n]);
    for (int unsigned i = 0; i < C; i++) mWave.push_back(1'b1);
    mLog.push_back(b);
  endtask

  always @(posedge clk) begin
    bit busy, last, dv;
    bit [7:0] by;
    dv = bus.i_TX_DV;
    by = bus.i_TX_Byte;
    if (rst) begin
      mWave.delete();
      mHeld  = 0;
      mDone  = 0;
      mValid = 1;
    end else begin
      busy  = (mWave.size() > 0);
      last  = (mWave.size() == 1);
      if (busy) void'(mWave.pop_front());
      mDone = last;
      if (!busy) begin
        if (dv) startFrame(by);
      end else if (last) begin
        if (mHeld) begin
          startFrame(mHoldByte);
          if (dv) mHoldByte = by;
          else    mHeld = 0;
        end else if (dv) startFrame(by);
      end else if (dv && !mHeld) begin
        mHeld     = 1;
        mHoldByte = by;
      end
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      check("serial", int'(bus.o_TX_Serial), (mWave.size() > 0) ? int'(mWave[0]) : 1);
      check("active", int'(bus.o_TX_Active), int'(mWave.size() > 0));
      check("done",   int'(bus.o_TX_Done),   int'(mDone));
      check("ready",  int'(bus.o_TX_Ready),  int'(!mHeld));
    end
  end

  // DUT-side observations: done pulse timestamps and contiguous active runs.
  int doneTimes[$];
  int runs[$];
  int run = 0;
  always @(negedge clk) begin
    if (bus.o_TX_Done) doneTimes.push_back(cyc);
    if (bus.o_TX_Active) run++;
    else if (run > 0) begin
      runs.push_back(run);
      run = 0;
    end
  end

  task automatic sendByte(input bit [7:0] b, output int strobeCyc);
    @(posedge clk); #1;
    bus.i_TX_DV   = 1'b1;
    bus.i_TX_Byte = b;
    strobeCyc     = cyc;
    @(posedge clk); #1;
    bus.i_TX_DV   = 1'b0;
    bus.i_TX_Byte = ~b;
  endtask

  task automatic waitIdle(input string name);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (mWave.size() == 0 && !mHeld && !bus.o_TX_Active) begin
        ok = 1;
        break;
      end
    end
    check(name, int'(ok), 1);
    @(negedge clk); #1;
  endtask

  task automatic collect(output logic [39:0] v);
    v = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      v = {v[38:0], bus.o_TX_Serial};
    end
  endtask

  initial begin
    int s;
    logic [39:0] line;
    bus.i_TX_DV   = 1'b0;
    bus.i_TX_Byte = '0;

    // Reset, then 50 idle cycles
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    doneTimes.delete();
    runs.delete();
    repeat (50) @(posedge clk);
    #1;
    check("idle_serial", int'(bus.o_TX_Serial), 1);
    check("idle_ready",  int'(bus.o_TX_Ready), 1);
    check("idle_done_count", doneTimes.size(), 0);
    check("idle_active_runs", runs.size(), 0);

    // Single frame 0xA5
    doneTimes.delete(); runs.delete();
    sendByte(8'hA5, s);
    collect(line);
    check("a5_line", int'(line[39:8]), 32'h0F0F00F0);
    check("a5_line_lo", int'(line[7:0]), 8'hFF);
    waitIdle("a5_idle");
    check("a5_done_count", doneTimes.size(), 1);
    check("a5_done_latency", doneTimes[0] - s, 41);
    check("a5_active_run", runs[0], 40);
    check("a5_log", int'(mLog[mLog.size()-1]), 8'hA5);

    // 0x3C then 0xFF queued during data bits
    doneTimes.delete(); runs.delete();
    sendByte(8'h3C, s);
    repeat (8) @(posedge clk);
    sendByte(8'hFF, s);
    check("b2b_ready_low", int'(bus.o_TX_Ready), 0);
    waitIdle("b2b_idle");
    check("b2b_done_count", doneTimes.size(), 2);
    check("b2b_done_gap", doneTimes[1] - doneTimes[0], 40);
    check("b2b_active_run", runs[0], 80);
    check("b2b_ready_back", int'(bus.o_TX_Ready), 1);
    check("b2b_log0", int'(mLog[mLog.size()-2]), 8'h3C);
    check("b2b_log1", int'(mLog[mLog.size()-1]), 8'hFF);

    // Strobe while holding is full is dropped
    doneTimes.delete(); runs.delete();
    sendByte(8'h5A, s);
    repeat (6) @(posedge clk);
    sendByte(8'h11, s);
    repeat (6) @(posedge clk);
    sendByte(8'h22, s);
    check("drop_ready_low", int'(bus.o_TX_Ready), 0);
    waitIdle("drop_idle");
    check("drop_active_run", runs[0], 80);
    check("drop_log0", int'(mLog[mLog.size()-2]), 8'h5A);
    check("drop_log1", int'(mLog[mLog.size()-1]), 8'h11);

    // Holding full plus strobe on the last stop cycle
    doneTimes.delete(); runs.delete();
    sendByte(8'h96, s);
    repeat (6) @(posedge clk);
    sendByte(8'h69, s);
    begin
      bit found = 0;
      for (int i = 0; i < 200; i++) begin
        if (mWave.size() == 1) begin found = 1; break; end
        @(posedge clk); #1;
      end
      check("sim_find_last_stop", int'(found), 1);
    end
    bus.i_TX_DV   = 1'b1;
    bus.i_TX_Byte = 8'h55;
    @(posedge clk); #1;
    bus.i_TX_DV   = 1'b0;
    bus.i_TX_Byte = 8'h00;
    check("sim_ready_stays_low", int'(bus.o_TX_Ready), 0);
    check("sim_serial_start", int'(bus.o_TX_Serial), 0);
    waitIdle("sim_idle");
    check("sim_done_count", doneTimes.size(), 3);
    check("sim_active_run", runs[0], 120);
    check("sim_log0", int'(mLog[mLog.size()-3]), 8'h96);
    check("sim_log1", int'(mLog[mLog.size()-2]), 8'h69);
    check("sim_log2", int'(mLog[mLog.size()-1]), 8'h55);

    // Reset during data bit 3 of 0x00, then 0x81
    doneTimes.delete(); runs.delete();
    sendByte(8'h00, s);
    repeat (16) @(posedge clk);
    #1;
    check("rst_pre_serial", int'(bus.o_TX_Serial), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_serial", int'(bus.o_TX_Serial), 1);
    check("rst_ready",  int'(bus.o_TX_Ready), 1);
    check("rst_active", int'(bus.o_TX_Active), 0);
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_done", doneTimes.size(), 0);
    sendByte(8'h81, s);
    collect(line);
    check("r81_line", int'(line[39:8]), 32'h0F000000);
    check("r81_line_lo", int'(line[7:0]), 8'hFF);
    waitIdle("r81_idle");
    check("r81_done_count", doneTimes.size(), 1);
    check("r81_done_latency", doneTimes[0] - s, 41);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

8N1 UART transmitter that serialises bytes onto a single TX line at a fixed baud set by a clock-per-bit parameter. It is the transmit-side counterpart of the board's UART receive path and shares its line format and bit timing. It includes a one-byte holding register so the upstream logic can queue the next byte while the current frame is on the wire, which gives back-to-back frames with no idle gap.

## Interface
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200); legal range ≥ 2
- i_Clk  input  1  system clock; all logic on rising edge
- i_Rst  input  1  synchronous, active-high reset
- i_TX_DV  input  1  byte-valid strobe; sampled every cycle
- i_TX_Byte  input  8  byte to send, captured when i_TX_DV & o_TX_Ready
- o_TX_Serial  output  1  serial line, idles high
- o_TX_Active  output  1  high while any frame bit is being driven
- o_TX_Done  output  1  one-cycle pulse per completed frame
- o_TX_Ready  output  1  high when the holding register is empty and a byte can be accepted

## Operation
- Frame format: one start bit (0), 8 data bits LSB first, one stop bit (1). No parity.
- States:
  - IDLE → START: on load of the shift register.
  - START → DATA: after CLKS_PER_BIT cycles.
  - DATA → STOP: after 8 bits, each lasting CLKS_PER_BIT cycles.
  - STOP → IDLE or START: after CLKS_PER_BIT cycles.
- Bit counter: 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It clears on every bit boundary.
- Bit index counter: 3 bits, 0..7. It wraps to 0 on DATA→STOP.
- Acceptance rule: a byte is accepted when i_TX_DV=1 and o_TX_Ready=1.
  - In IDLE, the byte loads the shift register directly, and the state goes to START. The holding register stays empty, so o_TX_Ready stays 1.
  - In any other state, the byte loads the holding register, and o_TX_Ready drops to 0.
- i_TX_DV while o_TX_Ready=0: ignored. The byte is dropped and the holding contents are unchanged.
- End of the stop bit (last STOP cycle):
  - If the holding register is full, its byte moves to the shift register, the state goes to START, and the holding register is marked empty.
  - Otherwise, if i_TX_DV=1 on that same cycle, the new byte loads the shift register directly and the state goes to START.
  - Otherwise, the state goes to IDLE.
- Simultaneous case: holding register full and i_TX_DV=1 on the last STOP cycle. The holding byte goes to the shift register and the new byte goes into holding. o_TX_Ready stays 0.
- i_TX_Byte is sampled only at acceptance. Later changes have no effect on the frame in flight.

## Timing
- Reset values: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1. State is IDLE, counters are 0, and the holding register is empty.
- Reset mid-frame aborts the frame. On the cycle after the reset edge, o_TX_Serial=1, and no o_TX_Done pulse is produced.
- All outputs are registered.
- Acceptance in IDLE on edge k:
  - o_TX_Serial=0 and o_TX_Active=1 from cycle k+1.
  - The start bit occupies cycles k+1 .. k+CLKS_PER_BIT.
  - Data bit n occupies the next CLKS_PER_BIT-cycle slot, for n = 0..7.
  - The stop bit ends at cycle k+10·CLKS_PER_BIT.
- o_TX_Done is high for exactly the one cycle after the last stop-bit cycle.
  - Isolated frame: this is the same cycle o_TX_Active returns to 0 and the state is IDLE.
  - Back-to-back frame: it coincides with the first start-bit cycle of the next frame.
- Back-to-back frames: o_TX_Active stays 1 continuously, and frame period = 10·CLKS_PER_BIT cycles exactly.
- o_TX_Ready returns to 1 on the cycle after the holding byte transfers to the shift register, unless the simultaneous case applies.

## Test plan
- Reset, then idle for 50 cycles → o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done never asserts.
- CLKS_PER_BIT=4; send 0xA5 with a one-cycle i_TX_DV → line shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; start begins 1 cycle after the strobe; a single o_TX_Done pulse arrives at cycle 41 after the strobe.
- CLKS_PER_BIT=4; send 0x3C, then 0xFF during its data bits → o_TX_Ready goes to 0; second frame starts with no gap (80 contiguous cycles); two o_TX_Done pulses 40 cycles apart; o_TX_Ready returns to 1.
- Queue 0x11, then assert DV with 0x22 while o_TX_Ready=0 → only 0x11 follows the first frame; 0x22 never appears.
- Holding full plus DV (0x55) on the last stop cycle → the held byte is sent next, then 0x55, as three contiguous frames.
- Assert i_Rst during data bit 3 of 0x00 → o_TX_Serial=1 the next cycle, no o_TX_Done, o_TX_Ready=1; a new byte 0x81 then transmits correctly.
